// File: rtl/idli_pkg.sv
// idli shared types: core word, register index and trace entry layout.
// Trace entry carries predicate fields; see IDLI_TRACE_PRED_EN in idli_trace_m.
package idli_pkg;

  localparam int NUM_REGS    = 16;
  localparam int DATA_W      = 16;
  localparam int TRACE_DEPTH = 4;

  typedef logic [1:0]                  ctr_t;
  typedef logic [DATA_W-1:0]           data_t;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_t;
  typedef logic [NUM_REGS-1:0]         mask_t;

  typedef struct packed {
    data_t pc;
    mask_t reg_mask;
    logic  pred_vld;
    logic  pred;
  } trace_ent_t;

  // Stored form when predicate tracking is built out.
  typedef struct packed {
    data_t pc;
    mask_t reg_mask;
  } trace_core_t;

  // One-hot mask bit for a register write; r0 is hardwired and never set.
  function automatic mask_t reg_bit(input reg_t r, input int nregs);
    mask_t m;
    m = '0;
    if (r != '0 && int'(r) < nregs)
      m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/idli_trace_fifo_m.sv
// idli trace FIFO: DEPTH-entry ring, power-of-two pointers.
// Push while full is accepted only if a pop happens on the same edge.
module idli_trace_fifo_m #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       gck,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       rdy,
  output logic                       vld,
  output logic                       full,
  output logic                       pop,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;

  assign vld   = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = vld && rdy;
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr];

  // Storage needs no reset; head is only meaningful while vld is high.
  always_ff @(posedge gck) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !wr_en)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/idli_trace_m.sv
// idli retirement trace: accumulates pc/reg writes/predicate per instruction.
// IDLI_TRACE_PRED_EN defined adds predicate tracking; otherwise pred fields read 0.
module idli_trace_m
  import idli_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int NREGS = NUM_REGS
) (
  input  logic                       gck,
  input  logic                       rst_n,
  input  ctr_t                       i_ctr,
  input  logic                       i_run_instr,
  input  logic                       i_mem_op,
  input  logic                       i_mem_last,
  input  logic                       i_enc_new,
  input  data_t                      i_pc,
  input  logic                       i_reg_wr,
  input  reg_t                       i_reg,
  input  logic                       i_pred_wr,
  input  logic                       i_pred_val,
  input  logic                       i_trc_rdy,
  input  logic                       i_ovf_clr,
  output logic                       o_trc_vld,
  output trace_ent_t                 o_trc_ent,
  output logic [$clog2(DEPTH+1)-1:0] o_trc_cnt,
  output logic                       o_trc_ovf
);

`ifdef IDLI_TRACE_PRED_EN
  typedef trace_ent_t fifo_ent_t;
  logic acc_pv, acc_p;
  logic nxt_pv, nxt_p;
`else
  typedef trace_core_t fifo_ent_t;
  logic unused_pred;
  assign unused_pred = i_pred_wr ^ i_pred_val;
`endif

  data_t     acc_pc, nxt_pc;
  mask_t     acc_mask, nxt_mask;
  logic      retire;
  logic      full;
  logic      pop;
  fifo_ent_t push_ent;
  fifo_ent_t head;

  assign retire = (i_ctr == 2'd3) && i_run_instr
               && (!i_mem_op || i_mem_last);

  // Accumulator view including this edge's updates.
  always_comb begin
    nxt_pc   = acc_pc;
    nxt_mask = acc_mask;
`ifdef IDLI_TRACE_PRED_EN
    nxt_pv   = acc_pv;
    nxt_p    = acc_p;
`endif
    if (i_ctr == 2'd0) begin
      if (i_enc_new)
        nxt_pc = i_pc;
      if (i_reg_wr)
        nxt_mask = acc_mask | reg_bit(i_reg, NREGS);
`ifdef IDLI_TRACE_PRED_EN
      if (i_pred_wr) begin
        nxt_pv = 1'b1;
        nxt_p  = i_pred_val;
      end
`endif
    end
  end

  // Accumulator register; retire clears per-instruction state, keeps pc.
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      acc_pc   <= '0;
      acc_mask <= '0;
`ifdef IDLI_TRACE_PRED_EN
      acc_pv   <= 1'b0;
      acc_p    <= 1'b0;
`endif
    end else begin
      acc_pc   <= nxt_pc;
      acc_mask <= retire ? '0 : nxt_mask;
`ifdef IDLI_TRACE_PRED_EN
      acc_pv   <= retire ? 1'b0 : nxt_pv;
      acc_p    <= retire ? 1'b0 : nxt_p;
`endif
    end
  end

  // Entry packing between accumulator, FIFO and output.
  always_comb begin
    push_ent.pc       = nxt_pc;
    push_ent.reg_mask = nxt_mask;
    o_trc_ent.pc       = head.pc;
    o_trc_ent.reg_mask = head.reg_mask;
`ifdef IDLI_TRACE_PRED_EN
    push_ent.pred_vld  = nxt_pv;
    push_ent.pred      = nxt_p;
    o_trc_ent.pred_vld = head.pred_vld;
    o_trc_ent.pred     = head.pred;
`else
    o_trc_ent.pred_vld = 1'b0;
    o_trc_ent.pred     = 1'b0;
`endif
  end

  idli_trace_fifo_m #(
    .DEPTH (DEPTH),
    .T     (fifo_ent_t)
  ) u_fifo (
    .gck   (gck),
    .rst_n (rst_n),
    .push  (retire),
    .din   (push_ent),
    .rdy   (i_trc_rdy),
    .vld   (o_trc_vld),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .cnt   (o_trc_cnt)
  );

  // Sticky overflow; a drop on the same edge beats the clear.
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n)
      o_trc_ovf <= 1'b0;
    else if (retire && full && !pop)
      o_trc_ovf <= 1'b1;
    else if (i_ovf_clr)
      o_trc_ovf <= 1'b0;
  end

endmodule
